pc_fetch_unit: RTL and testbench

- Program-counter register and instruction-fetch sequencer; sits directly upstream of the next-PC selector.
- Drives `pc` to the next-PC selector and to instruction memory.
- Latches `npc` back from the next-PC selector when the current instruction retires.
- Runs a request/response handshake with instruction memory and presents the fetched instruction to decode with valid/ready flow control.

---
 rtl/pc_fetch_unit_pkg.sv | 25 ++
 rtl/pc_reg.sv | 25 ++
 rtl/pc_fetch_unit.sv | 106 ++++++++++
 tb/tb_pc_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch unit: FSM state encoding, the NOP
// instruction used as the reset value of the holding register, and the
// next-PC selector opcodes that live alongside them.
`ifndef PC_FETCH_UNIT_PKG_SV
`define PC_FETCH_UNIT_PKG_SV

// Next-PC selector opcodes (consumed downstream of this block).
`define NPC_PLUS4  2'd0
`define NPC_BRANCH 2'd1
`define NPC_JAL    2'd2
`define NPC_JALR   2'd3

package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

`endif

// File: rtl/pc_reg.sv
// Program-counter register: asynchronous reset to RESET_ADDR, loads on
// retire either the next PC or the trap vector.
module pc_reg #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] TRAP_ADDR  = 32'h0000_0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              trap,
  input  logic [ADDR_W-1:0] npc,
  output logic [ADDR_W-1:0] pc
);

  // PC only moves on a load; trap selects the fixed trap vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_ADDR;
    end else if (load) begin
      pc <= trap ? TRAP_ADDR : npc;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register plus fetch sequencer REQ -> WAIT -> HOLD.
// Optional misaligned-target trap is enabled with macro PC_ALIGN_CHECK_EN.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; valid never waits on ready, and the offered payload
// (imem_addr / inst) is held stable while valid is high and ready is low.
// Memory returns exactly one imem_rsp_valid pulse per accepted request,
// no earlier than the cycle after acceptance. inst_ready in HOLD retires
// the held instruction and loads the next PC.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRAP_ADDR  = 32'h0000_0100,
  parameter int          ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] npc,
  output logic [ADDR_W-1:0] pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic              fetch_err
);

  fetch_state_t state;
  logic         retire;
  logic         misaligned;

  assign retire = (state == ST_HOLD) && inst_ready;

`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = |npc[1:0];

  // One-cycle error pulse registered at the retire edge of a bad target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= retire && misaligned;
    end
  end
`else
  assign misaligned = 1'b0;
  assign fetch_err  = 1'b0;
`endif

  pc_reg #(
    .ADDR_W    (ADDR_W),
    .RESET_ADDR(RESET_ADDR[ADDR_W-1:0]),
    .TRAP_ADDR (TRAP_ADDR[ADDR_W-1:0])
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .load(retire),
    .trap(misaligned),
    .npc (npc),
    .pc  (pc)
  );

  // Fetch address is the PC itself, so it is stable for the whole instruction.
  assign imem_addr      = pc;
  assign imem_req_valid = (state == ST_REQ) && !rst;

  // Fetch FSM and instruction holding register; responses outside WAIT
  // and retire strobes outside HOLD fall through untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_REQ;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (imem_req_ready) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= ST_REQ;
          end
        end
        default: begin
          inst_valid <= 1'b0;
          state      <= ST_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by randomized
// memory/decode behaviour checked against a transaction-level model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] TRAP_ADDR  = 32'h0000_0100;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] npc = '0;
  logic [31:0] pc;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic        fetch_err;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .RESET_ADDR(RESET_ADDR),
    .TRAP_ADDR (TRAP_ADDR),
    .ADDR_W    (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .npc           (npc),
    .pc            (pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .fetch_err     (fetch_err)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Transaction-level model: which phase the current instruction is in,
  // the PC it was fetched from, and the last instruction delivered.
  logic [31:0] m_pc   = RESET_ADDR;
  logic [31:0] m_inst = NOP;
  bit          m_wait = 0;
  bit          m_hold = 0;
  bit          m_err  = 0;
  int          lat_cnt = 0;
  bit          did_retire = 0;

  // Stimulus knobs
  int          p_rr = 100, p_ir = 0, p_stray = 0;
  int          lat_min = 1, lat_max = 1;
  int          npc_mode = 1;
  logic [31:0] fix_npc = 32'h4;
  bit          use_fix_rdata = 1;
  logic [31:0] fix_rdata = 32'h0040_0093;

  function automatic bit chance(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  function automatic logic [31:0] pick_npc();
    logic [31:0] r;
    r = $urandom;
    case (npc_mode)
      0:       return m_pc + 32'd4;
      1:       return fix_npc;
      default: return chance(20) ? r : (r & 32'hFFFF_FFFC);
    endcase
  endfunction

  task automatic check_outputs();
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("req_valid", 32'(imem_req_valid), 32'(!rst && !m_wait && !m_hold));
    check("inst_valid", 32'(inst_valid), 32'(m_hold));
    check("inst", inst, m_inst);
    check("fetch_err", 32'(fetch_err), 32'(m_err));
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs();
    bit          in_req;
    logic [31:0] exp_inst;
    in_req         = !m_wait && !m_hold;
    did_retire     = 0;
    m_err          = 0;
    imem_req_ready = chance(p_rr);
    inst_ready     = chance(p_ir);
    imem_rsp_valid = 1'b0;
    imem_rdata     = $urandom;
    npc            = $urandom;
    if (m_hold && inst_ready) begin
      if (exp_q.size() == 0) begin
        check("retire_q_nonempty", 32'd0, 32'd1);
      end else begin
        exp_inst = exp_q.pop_front();
        check("retire_inst", inst, exp_inst);
      end
      npc = pick_npc();
`ifdef PC_ALIGN_CHECK_EN
      if (npc[1:0] != 2'b00) begin
        m_pc  = TRAP_ADDR;
        m_err = 1;
      end else begin
        m_pc = npc;
      end
`else
      m_pc = npc;
`endif
      m_hold     = 0;
      did_retire = 1;
    end else if (m_wait) begin
      if (lat_cnt > 1) begin
        lat_cnt--;
      end else begin
        imem_rsp_valid = 1'b1;
        if (use_fix_rdata) imem_rdata = fix_rdata;
        exp_q.push_back(imem_rdata);
        m_inst = imem_rdata;
        m_wait = 0;
        m_hold = 1;
      end
    end else if (in_req && imem_req_ready) begin
      m_wait  = 1;
      lat_cnt = int'($urandom_range(lat_max, lat_min));
    end else begin
      imem_rsp_valid = chance(p_stray);
    end
  endtask

  task automatic eval_cycle();
    check_outputs();
    drive_inputs();
  endtask

  task automatic step();
    @(negedge clk);
    eval_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
    m_pc    = RESET_ADDR;
    m_inst  = NOP;
    m_wait  = 0;
    m_hold  = 0;
    m_err   = 0;
    lat_cnt = 0;
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      check_outputs();
    end
    rst = 1'b0;
    drive_inputs();
  endtask

  task automatic run_until_retire(input string tag, input int budget);
    int n;
    n = 0;
    did_retire = 0;
    while (!did_retire && n < budget) begin
      step();
      n++;
    end
    check({tag, "_retired"}, 32'(did_retire), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset, always-ready memory, 1-cycle response.
    do_reset();
    step();
    @(negedge clk);
    check("t1_inst_valid", 32'(inst_valid), 32'd1);
    check("t1_inst", inst, 32'h0040_0093);
    check("t1_addr", imem_addr, 32'h0);
    eval_cycle();

    // Decode stalls 5 cycles in HOLD.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_inst_stable", inst, 32'h0040_0093);
      check("t2_pc_stable", pc, 32'h0);
      check("t2_inst_valid", 32'(inst_valid), 32'd1);
      eval_cycle();
    end
    p_ir    = 100;
    fix_npc = 32'h4;
    p_rr    = 0;
    run_until_retire("t2", 4);

    // Memory not ready for 4 cycles in REQ.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_req_valid", 32'(imem_req_valid), 32'd1);
      check("t3_addr", imem_addr, 32'h4);
      check("t3_inst_valid", 32'(inst_valid), 32'd0);
      eval_cycle();
    end

    // Taken branch to 0x40.
    p_rr    = 100;
    fix_npc = 32'h40;
    run_until_retire("t4", 20);
    @(negedge clk);
    check("t4_pc", pc, 32'h40);
    check("t4_addr", imem_addr, 32'h40);
    eval_cycle();

    // Misaligned target 0x22.
    fix_npc = 32'h22;
    run_until_retire("t6", 20);
    @(negedge clk);
`ifdef PC_ALIGN_CHECK_EN
    check("t6_pc", pc, TRAP_ADDR);
    check("t6_err", 32'(fetch_err), 32'd1);
`else
    check("t6_pc", pc, 32'h22);
    check("t6_err", 32'(fetch_err), 32'd0);
`endif
    eval_cycle();
    @(negedge clk);
    check("t6_err_clear", 32'(fetch_err), 32'd0);
    eval_cycle();

    // Reset while waiting on memory, then a stray response.
    lat_min = 3;
    lat_max = 3;
    begin
      int n;
      n = 0;
      while (!m_wait && n < 20) begin
        step();
        n++;
      end
      check("t5_reached_wait", 32'(m_wait), 32'd1);
    end
    p_rr    = 0;
    p_stray = 100;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t5_inst_valid", 32'(inst_valid), 32'd0);
      check("t5_inst", inst, NOP);
      check("t5_pc", pc, RESET_ADDR);
      check("t5_req_valid", 32'(imem_req_valid), 32'd1);
      eval_cycle();
    end

    // Randomized traffic.
    p_rr          = 70;
    p_ir          = 60;
    p_stray       = 30;
    lat_min       = 1;
    lat_max       = 4;
    use_fix_rdata = 0;
    npc_mode      = 2;
    repeat (800) step();
    npc_mode = 0;
    repeat (200) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
